// File: rtl/mem_lsu_port.sv
// Load/store unit port: takes one pipeline request at a time, drives the memory
// read or write port for MEM_LAT cycles, and returns an extended, held response.
module mem_lsu_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  pMem_bRdEn,
  output logic [ADDR_WIDTH-1:0] pMem_bRdAddrB,
  input  logic [DATA_WIDTH-1:0] pMem_bRdDataB,
  output logic                  pMem_bWrEn,
  output logic [ADDR_WIDTH-1:0] pMem_bWrAddr,
  output logic [DATA_WIDTH-1:0] pMem_bWrData,
  output logic                  pMem_bWrMask_0,
  output logic                  pMem_bWrMask_1,
  output logic                  pMem_bWrMask_2,
  output logic                  pMem_bWrMask_3
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_first;
  logic                  r_wr;
  logic                  r_signed;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_hs;
  logic                  w_bad;
  logic                  w_access;
  logic                  w_load;
  logic                  w_store;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_hs = req_valid && (r_state == S_IDLE);

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    w_bad = 1'b0;
    case (req_size)
      SZ_BYTE: w_bad = 1'b0;
      SZ_HALF: w_bad = req_addr[0];
      SZ_WORD: w_bad = |req_addr[1:0];
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_ext = pMem_bRdDataB;
    case (r_size)
      SZ_BYTE: w_ext = {{24{r_signed & pMem_bRdDataB[7]}},  pMem_bRdDataB[7:0]};
      SZ_HALF: w_ext = {{16{r_signed & pMem_bRdDataB[15]}}, pMem_bRdDataB[15:0]};
      default: w_ext = pMem_bRdDataB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_first  <= 1'b0;
      r_wr     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_wr     <= req_wr;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            // Bad requests skip the memory entirely and answer next cycle.
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_err   <= 1'b0;
              r_cnt   <= CNT_INIT;
              r_first <= 1'b1;
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_first <= 1'b0;
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            if (!r_wr) r_rdata <= w_ext;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_access = (r_state == S_ACCESS);
  assign w_load   = w_access && !r_wr;
  assign w_store  = w_access && r_wr;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign pMem_bRdEn    = w_load;
  assign pMem_bRdAddrB = w_load ? r_addr : '0;

  // The write strobe fires once; address/data stay up for the whole access.
  assign pMem_bWrEn     = w_store && r_first;
  assign pMem_bWrAddr   = w_store ? r_addr  : '0;
  assign pMem_bWrData   = w_store ? r_wdata : '0;
  assign pMem_bWrMask_3 = w_store;
  assign pMem_bWrMask_2 = w_store && (r_size != SZ_BYTE);
  assign pMem_bWrMask_1 = w_store && (r_size == SZ_WORD);
  assign pMem_bWrMask_0 = w_store && (r_size == SZ_WORD);

endmodule

// File: doc/mem_lsu_port.md
MEM_LSU_PORT -- requirements
Module: mem_lsu_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter MEM_LAT, default 1: number of cycles the memory port is driven per access; legal range 1..15.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  1  pipeline request valid.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_wr  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  ADDR_WIDTH  byte address.
REQ-010 req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
REQ-011 req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-012 req_signed  in  1  sign-extend load result.
REQ-013 resp_valid  out  1  response valid.
REQ-014 resp_ready  in  1  pipeline accepts the response.
REQ-015 resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-016 resp_err  out  1  misaligned address or illegal size.
REQ-017 pMem_bRdEn  out  1; pMem_bRdAddrB  out  ADDR_WIDTH; pMem_bRdDataB  in  DATA_WIDTH: memory data read port.
REQ-018 pMem_bWrEn  out  1; pMem_bWrAddr  out  ADDR_WIDTH; pMem_bWrData  out  DATA_WIDTH; pMem_bWrMask_0..pMem_bWrMask_3  out  1 each: memory write port.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-020 SHALL assert req_ready only in IDLE; a handshake is req_valid && req_ready.
REQ-021 SHALL latch req_wr, req_addr, req_wdata, req_size and req_signed on handshake.
- Misaligned = half with addr[0] = 1, or word with addr[1:0] != 0.
REQ-022 On handshake, SHALL go to ACCESS if the request is legal and aligned, else to RESP with resp_err = 1 and resp_rdata = 0; an erroneous request SHALL make no memory access.
REQ-023 SHALL stay in ACCESS exactly MEM_LAT cycles, counted by a 4-bit down-counter loaded with MEM_LAT-1, then go to RESP.
REQ-024 Load in ACCESS: pMem_bRdEn = 1 and pMem_bRdAddrB = latched address on every ACCESS cycle.
REQ-025 Load: SHALL capture pMem_bRdDataB on the last ACCESS cycle.
REQ-026 Store in ACCESS: pMem_bWrEn = 1 on the first ACCESS cycle only; pMem_bWrAddr = latched address and pMem_bWrData = latched wdata on all ACCESS cycles.
REQ-027 Store masks SHALL be: byte -> mask_3 only; half -> mask_2 and mask_3; word -> all four; data stays LSB-aligned (no lane shift).
REQ-028 Load extraction SHALL take bits [7:0] / [15:0] / [31:0] of the captured data, sign- or zero-extended per latched req_signed; word loads are unchanged.
REQ-029 Outside ACCESS, all pMem_* outputs SHALL be 0.
REQ-030 In RESP, SHALL hold resp_valid = 1 with stable resp_rdata and resp_err until resp_ready = 1, then go to IDLE.
REQ-031 No new request SHALL be accepted in the RESP-to-IDLE transition cycle.
- Minimum spacing between handshakes is MEM_LAT + 2 cycles.
REQ-032 Latency SHALL be: handshake at cycle T -> resp_valid first asserted at T + 1 + MEM_LAT for a legal request, T + 1 for an error.

Reset
REQ-033 While reset_n = 0 at a clock edge, SHALL enter IDLE with counter = 0 and all captured registers = 0.
- After that edge: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, all pMem_* = 0.
REQ-034 Reset in ACCESS or RESP SHALL abandon the operation: no response, enables low from the next edge, and no further write is issued.

Verification
REQ-035 Word load, MEM_LAT = 1, addr 0x80000010, memory returns 0xDEADBEEF -> RdEn high exactly one cycle with RdAddrB 0x80000010; resp_valid at T + 2; rdata 0xDEADBEEF; err 0.
REQ-036 Signed byte load, data 0x00000080 -> rdata 0xFFFFFF80; same access unsigned -> 0x00000080; signed half, data 0x00008001 -> 0xFFFF8001.
REQ-037 Half store, addr 0x100, wdata 0x1234ABCD -> WrEn pulses one cycle; masks {0,3} = {0,0,1,1}; WrData 0x1234ABCD; rdata 0.
REQ-038 Word load at 0x102 and size = 11 request -> no RdEn/WrEn, resp_valid at T + 1 with err = 1, rdata 0.
REQ-039 Back-pressure: resp_ready held 0 for 5 cycles -> resp_valid and rdata stable and req_ready stays 0; accepted on the cycle resp_ready = 1.
REQ-040 MEM_LAT = 3 store with reset_n = 0 on the 2nd ACCESS cycle -> exactly one WrEn pulse, no resp_valid, req_ready = 1 after the reset edge.
